// File: rtl/axis_switch_pkg.sv
// Shared constants and width-free helpers for the AXI-Stream switch and its
// per-port input FIFOs.
package axis_switch_pkg;

  localparam int unsigned MIN_FIFO_DEPTH = 4;

  // Pointer width: one extra MSB so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= MIN_FIFO_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module axis_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // which entries are valid, and a reset here would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward gating, sitting in front of
// each switch input port.
module axis_pkt_fifo
  import axis_switch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ID_WIDTH    = 1,
  parameter int unsigned DEST_WIDTH  = 1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned DEPTH       = 16,
  parameter bit          PACKET_MODE = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic [ID_WIDTH-1:0]       s_id,
  input  logic [DEST_WIDTH-1:0]     s_dest,
  input  logic [USER_WIDTH-1:0]     s_user,
  input  logic [DATA_WIDTH/8-1:0]   s_keep,
  input  logic                      s_last,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [ID_WIDTH-1:0]       m_id,
  output logic [DEST_WIDTH-1:0]     m_dest,
  output logic [USER_WIDTH-1:0]     m_user,
  output logic [DATA_WIDTH/8-1:0]   m_keep,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    pkt_count
);

  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned AW     = PTR_W - 1;
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned WORD_W = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + KEEP_W + 1;

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $fatal(1, "axis_pkt_fifo: DEPTH must be a power of 2 and at least 4");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $fatal(1, "axis_pkt_fifo: DATA_WIDTH must be a non-zero multiple of 8");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  pkt_cnt;
  logic              out_open;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              release_ok;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Each release term only falls on a pop, so a presented beat never retracts.
  if (PACKET_MODE) begin : g_gate
    assign release_ok = (pkt_cnt != '0) || full || out_open;
  end else begin : g_plain
    assign release_ok = 1'b1;
  end

  assign m_valid = !empty && release_ok;

  assign wr_word = {s_id, s_dest, s_user, s_keep, s_last, s_data};
  assign {m_id, m_dest, m_user, m_keep, m_last, m_data} = rd_word;

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt <= '0;
    end else if ((push && s_last) && !(pop && m_last)) begin
      pkt_cnt <= pkt_cnt + PTR_W'(1);
    end else if (!(push && s_last) && (pop && m_last)) begin
      pkt_cnt <= pkt_cnt - PTR_W'(1);
    end
  end

  // Set once a packet's head has left, so an oversize packet released by
  // `full` keeps flowing until its last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_open <= 1'b0;
    end else if (pop) begin
      out_open <= !m_last;
    end
  end

  assign level     = wr_ptr - rd_ptr;
  assign pkt_count = pkt_cnt;

endmodule
